// File: rtl/wb_bist_pkg.sv
// Shared types and helpers for the Wishbone RAM BIST master.
package wb_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_GAP,
    RD,
    RD_GAP,
    DONE
  } bist_state_t;

  localparam logic [3:0] SEL_ALL = 4'hF;

  // Pattern stored at word idx: seed with the zero-extended index folded in.
  function automatic logic [31:0] bist_pattern(input logic [31:0] seed, input logic [31:0] idx);
    return seed ^ idx;
  endfunction

endpackage

// File: rtl/wb_single_master.sv
// One Wishbone B4 classic transfer at a time: owns the bus registers,
// ack detection and the per-transfer timeout down-counter.
module wb_single_master
  import wb_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_sys,
  input  logic                  rst_b,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  timeout,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [ADDR_WIDTH+1:0] wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  input  logic [31:0]           wbm_dat_i,
  input  logic                  wbm_ack_i
);

  // Counter holds the remaining wait cycles minus one; terminal count is zero.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] tmr;

  assign done    = wbm_stb_o & wbm_ack_i;
  assign timeout = wbm_stb_o & ~wbm_ack_i & (tmr == '0);
  assign rdata   = wbm_dat_i;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      tmr       <= '0;
    end else if (done || timeout) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      tmr       <= '0;
    end else if (wbm_stb_o) begin
      tmr <= tmr - 1'b1;
    end else if (req) begin
      wbm_cyc_o <= 1'b1;
      wbm_stb_o <= 1'b1;
      wbm_we_o  <= we;
      wbm_sel_o <= SEL_ALL;
      wbm_adr_o <= {addr, 2'b00};
      wbm_dat_o <= we ? wdata : 32'h0;
      tmr       <= CW'(TIMEOUT - 1);
    end
  end

endmodule

// File: rtl/wb_ram_bist_master.sv
// Wishbone RAM BIST: writes a seed-derived pattern to every word, reads it
// back, and holds pass/fail plus the first failing address and data.
//
// state  | meaning
// IDLE   | waiting for start_i
// WR     | write transfer of word idx in flight
// WR_GAP | one idle bus cycle between writes
// RD     | read transfer of word idx in flight
// RD_GAP | one idle bus cycle between reads
// DONE   | result valid; start_i restarts
module wb_ram_bist_master
  import wb_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  start_i,
  input  logic [31:0]           seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [31:0]           fail_data_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [ADDR_WIDTH+1:0] wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  input  logic [31:0]           wbm_dat_i,
  input  logic                  wbm_ack_i
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  bist_state_t           state, nxt_state;
  logic [ADDR_WIDTH-1:0] idx, nxt_idx;
  logic [31:0]           seed, nxt_seed;
  logic                  launch;
  logic                  start_ok, rd_match, is_last;
  logic                  req, req_we;
  logic [31:0]           req_wdata;
  logic                  bus_done, bus_timeout;
  logic [31:0]           bus_rdata;

  assign start_ok  = ((state == IDLE) || (state == DONE)) && start_i;
  assign is_last   = (idx == LAST);
  assign rd_match  = (bus_rdata == bist_pattern(seed, 32'(idx)));
  assign req_wdata = bist_pattern(seed, 32'(nxt_idx));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state  <= IDLE;
      idx    <= '0;
      seed   <= '0;
      launch <= 1'b0;
    end else begin
      state  <= nxt_state;
      idx    <= nxt_idx;
      seed   <= nxt_seed;
      launch <= start_ok;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_seed  = seed;
    case (state)
      IDLE, DONE: begin
        if (start_i) begin
          nxt_state = WR;
          nxt_idx   = '0;
          nxt_seed  = seed_i;
        end
      end
      WR: begin
        if (bus_timeout)   nxt_state = DONE;
        else if (bus_done) nxt_state = WR_GAP;
      end
      WR_GAP: begin
        if (is_last) begin
          nxt_state = RD;
          nxt_idx   = '0;
        end else begin
          nxt_state = WR;
          nxt_idx   = idx + 1'b1;
        end
      end
      RD: begin
        if (bus_timeout) nxt_state = DONE;
        else if (bus_done) nxt_state = (!rd_match || is_last) ? DONE : RD_GAP;
      end
      RD_GAP: begin
        nxt_state = RD;
        nxt_idx   = idx + 1'b1;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // The first word launches one cycle after start; later words launch as the gap ends.
  always_comb begin
    busy_o = (state != IDLE) && (state != DONE);
    done_o = (state == DONE);
    req    = launch || (state == WR_GAP) || (state == RD_GAP);
    req_we = (nxt_state == WR);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
      fail_addr_o <= '0;
      fail_data_o <= '0;
    end else if (start_ok) begin
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
      fail_addr_o <= '0;
      fail_data_o <= '0;
    end else if (((state == WR) || (state == RD)) && bus_timeout) begin
      pass_o      <= 1'b0;
      timeout_o   <= 1'b1;
      fail_addr_o <= idx;
      fail_data_o <= '0;
    end else if ((state == RD) && bus_done) begin
      if (!rd_match) begin
        pass_o      <= 1'b0;
        fail_addr_o <= idx;
        fail_data_o <= bus_rdata;
      end else if (is_last) begin
        pass_o <= 1'b1;
      end
    end
  end

  wb_single_master #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) u_master (
    .clk_sys   (wb_clk_i),
    .rst_b     (wb_rst_ni),
    .req       (req),
    .we        (req_we),
    .addr      (nxt_idx),
    .wdata     (req_wdata),
    .done      (bus_done),
    .rdata     (bus_rdata),
    .timeout   (bus_timeout),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

endmodule
